rv_ex_decode_alu: RTL and testbench
===================================

Name: rv_ex_decode_alu

Overview:
- Single-issue RV32 execute-slice block: main control decode (opcode to control bits), ALU-control decode (ALUOp/funct3/funct7[30] to 4-bit op) and 32-bit ALU with zero flag.
- Sits between the ID stage register file/immediate generator and the EX/MEM pipeline register.
- All outputs are registered once, forming the EX-stage output register.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  instruction/operands valid this cycle
bubble  in  1  hazard bubble: forces all decoded control bits to 0
instr  in  32  instruction word (opcode [6:0], funct3 [14:12], bit 30)
rs1_val  in  32  operand A (already forwarded)
rs2_val  in  32  operand B register value (already forwarded)
imm  in  32  sign-extended immediate
out_valid  out  1  registered in_valid
alu_result  out  32  registered ALU result
zero  out  1  registered (result == 0)
alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write  out  1 each  registered control bits
alu_op  out  2  registered ALUOp
alu_ctl  out  4  registered ALU control code
branch_taken  out  1  registered branch & zero

Behaviour:
- Reset: when rst_n=0 at a rising edge, all outputs become 0. Reset takes priority over every other input.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N. No back-pressure.
- Main decode (opcode to alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write, alu_op):
  - 0110011 R: 0,0,0,0,0,1,10
  - 0010011 I-ALU: 1,0,0,0,0,1,11
  - 0000011 load: 1,1,1,0,0,1,00
  - 0100011 store: 1,0,0,1,0,0,00
  - 1100011 branch: 0,0,0,0,1,0,01
  - Any other opcode: all 0, alu_op 00.
- bubble=1: all control bits and alu_op are 0. The ALU still computes with alu_ctl derived from alu_op=00 (ADD).
- Operand B = alu_src ? imm : rs2_val. alu_src here is the post-bubble value.
- ALU-control decode:
  - alu_op 00: ADD 0010.
  - alu_op 01: SUB 0110.
  - alu_op 10, by funct3:
    - 000: ADD if bit30=0, else SUB
    - 111: AND 0000
    - 110: OR 0001
    - 100: XOR 0011
    - 001: SLL 0100
    - 101: SRL 0101 if bit30=0, else SRA 1101
    - 010: SLT 0111
    - 011: SLTU 1000
  - alu_op 11: same as 10, except funct3 000 is always ADD (bit30 ignored).
  - Any unlisted code: ADD.
- ALU operations:
  - ADD/SUB: modulo 2^32, no overflow flag.
  - Shifts use B[4:0]. SRA is arithmetic.
  - SLT signed and SLTU unsigned; result is 32-bit 0 or 1.
  - Unknown alu_ctl: result 0.
  - zero = (result == 32'h0).
- in_valid=0: datapath outputs are still computed and registered; out_valid=0 qualifies them.
- Undefined-opcode and bubble cases produce no write/memory side-effect bits.

Decomposition:
- Shared package: opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH), ALUOp codes, 4-bit ALU control codes, control-bundle struct.
- Combinational sub-modules: rv_main_decode, rv_alu_ctl_decode, rv_alu32.
- Top level adds the operand mux, bubble gating and the output register.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> all outputs 0. Release with R-type add -> out_valid=1 one cycle later.
- R-type add/sub: instr 0x002081B3, rs1=7, rs2=5 -> result 12, alu_ctl 0010, reg_write 1. instr 0x402081B3 -> result 2, alu_ctl 0110.
- I-type/load/store:
  - addi (opcode 0010011, bit30=1), rs1=10, imm=-3 -> result 7 (ADD, not SUB), alu_src 1.
  - lw: rs1=0x100, imm=8 -> result 0x108, mem_read 1, mem_to_reg 1.
  - sw -> mem_write 1, reg_write 0.
- Branch: beq, rs1=rs2=0x55 -> zero 1, branch_taken 1. With rs2=0x56 -> zero 0, branch_taken 0, result 0xFFFFFFFF.
- Logic/shift/compare:
  - and 0xF0F0&0x0FF0 -> 0x00F0.
  - sra 0x80000000 by 4 -> 0xF8000000.
  - slt -1<1 -> 1.
  - sltu 0xFFFFFFFF<1 -> 0.
- Bubble and illegal opcode:
  - bubble=1 with lw -> all control 0, alu_op 00.
  - opcode 1111111 -> all control 0.
  - In both cases result = rs1+rs2.

Source files
------------

// File: rtl/rv_ex_decode_alu_pkg.sv
// ---------------------------------------------------------------------------
// rv_ex_decode_alu_pkg
// Shared definitions for the RV32 execute slice:
//   - major opcodes recognised by the main decoder
//   - ALUOp codes passed from the main decoder to the ALU-control decoder
//   - 4-bit ALU control codes understood by rv_alu32
//   - ctrl_t, the control bundle produced by the main decoder
// ---------------------------------------------------------------------------
package rv_ex_decode_alu_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD = 2'b00;  // address generation
  localparam logic [1:0] ALUOP_SUB = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_R   = 2'b10;  // register-register, funct7[30] honoured
  localparam logic [1:0] ALUOP_I   = 2'b11;  // register-immediate

  // ALU control codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Control bundle from the main decoder
  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/rv_alu32.sv
// ---------------------------------------------------------------------------
// rv_alu32
// Combinational 32-bit ALU.
// Ports:
//   a        in  32  operand A
//   b        in  32  operand B (shift amount taken from b[4:0])
//   alu_ctl  in  4   operation code
//   result   out 32  result; 0 for codes the ALU does not implement
// ---------------------------------------------------------------------------
module rv_alu32
  import rv_ex_decode_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_ctl,
  output logic [31:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rv_alu_ctl_decode.sv
// ---------------------------------------------------------------------------
// rv_alu_ctl_decode
// Combinational ALU-control decoder.
// Ports:
//   alu_op      in  2  ALUOp from the (bubble-gated) main decoder
//   funct3      in  3  instr[14:12]
//   funct7_b30  in  1  instr[30]
//   alu_ctl     out 4  ALU operation code
// Register-immediate ops ignore bit 30 for funct3=000 because that bit belongs
// to the immediate (there is no SUBI); for funct3=101 it still selects SRAI.
// ---------------------------------------------------------------------------
module rv_alu_ctl_decode
  import rv_ex_decode_alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_b30,
  output logic [3:0] alu_ctl
);

  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_R, ALUOP_I: begin
        case (funct3)
          3'b000:  alu_ctl = (alu_op == ALUOP_R && funct7_b30) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctl = ALU_SLL;
          3'b010:  alu_ctl = ALU_SLT;
          3'b011:  alu_ctl = ALU_SLTU;
          3'b100:  alu_ctl = ALU_XOR;
          3'b101:  alu_ctl = funct7_b30 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctl = ALU_OR;
          3'b111:  alu_ctl = ALU_AND;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_main_decode.sv
// ---------------------------------------------------------------------------
// rv_main_decode
// Combinational main control decoder: major opcode -> control bundle.
// Ports:
//   opcode  in  7        instr[6:0]
//   ctrl    out ctrl_t   alu_src, mem_to_reg, mem_read, mem_write, branch,
//                        reg_write, alu_op
// Unrecognised opcodes decode to an all-zero bundle, so they never raise a
// register write or memory access.
// ---------------------------------------------------------------------------
module rv_main_decode
  import rv_ex_decode_alu_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R:      ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_R};
      OP_I:      ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_I};
      OP_LOAD:   ctrl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ALUOP_ADD};
      OP_STORE:  ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_ADD};
      OP_BRANCH: ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_SUB};
      default:   ctrl = '0;
    endcase
  end

endmodule

// File: rtl/rv_ex_decode_alu.sv
// ---------------------------------------------------------------------------
// rv_ex_decode_alu
// RV32 execute slice: main decode, ALU-control decode, operand-B mux and ALU,
// with every output registered once (1-cycle latency, no back-pressure).
// Ports:
//   clk, rst_n             clock, synchronous active-low reset (all outputs 0)
//   in_valid               operands/instruction valid this cycle
//   bubble                 hazard bubble: zeroes the decoded control bundle
//   instr                  instruction word
//   rs1_val, rs2_val, imm  operand A, register operand B, immediate
//   out_valid              registered in_valid
//   alu_result, zero       registered ALU result and (result == 0)
//   alu_src .. reg_write   registered control bits
//   alu_op, alu_ctl        registered ALUOp and ALU control code
//   branch_taken           registered branch & zero
// The datapath is computed and registered even when in_valid=0; out_valid
// alone qualifies it.
// ---------------------------------------------------------------------------
module rv_ex_decode_alu
  import rv_ex_decode_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            bubble,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            alu_src,
  output logic            mem_to_reg,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            reg_write,
  output logic [1:0]      alu_op,
  output logic [3:0]      alu_ctl,
  output logic            branch_taken
);

  ctrl_t           dec_ctrl;
  ctrl_t           ctrl_next;
  logic [3:0]      alu_ctl_next;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result_next;
  logic            zero_next;
  logic            branch_taken_next;

  ctrl_t           ctrl_reg;
  logic            out_valid_reg;
  logic [XLEN-1:0] alu_result_reg;
  logic            zero_reg;
  logic [3:0]      alu_ctl_reg;
  logic            branch_taken_reg;

  // Instruction fields not consumed by this slice (register indices,
  // funct7 bits other than 30).
  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instr[31], instr[29:15], instr[11:7]};

  rv_main_decode u_main_decode (
    .opcode (instr[6:0]),
    .ctrl   (dec_ctrl)
  );

  // A bubble kills the whole bundle; alu_op falls to 00, so the ALU still
  // runs an ADD on rs1/rs2 but nothing downstream acts on it.
  assign ctrl_next = bubble ? ctrl_t'('0) : dec_ctrl;

  rv_alu_ctl_decode u_alu_ctl_decode (
    .alu_op     (ctrl_next.alu_op),
    .funct3     (instr[14:12]),
    .funct7_b30 (instr[30]),
    .alu_ctl    (alu_ctl_next)
  );

  // Operand-B mux driven by the post-bubble alu_src.
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_op_b
    assign op_b[gi] = ctrl_next.alu_src ? imm[gi] : rs2_val[gi];
  end

  rv_alu32 u_alu (
    .a       (rs1_val),
    .b       (op_b),
    .alu_ctl (alu_ctl_next),
    .result  (alu_result_next)
  );

  assign zero_next         = (alu_result_next == '0);
  assign branch_taken_next = ctrl_next.branch & zero_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg    <= 1'b0;
      alu_result_reg   <= '0;
      zero_reg         <= 1'b0;
      ctrl_reg         <= '0;
      alu_ctl_reg      <= '0;
      branch_taken_reg <= 1'b0;
    end else begin
      out_valid_reg    <= in_valid;
      alu_result_reg   <= alu_result_next;
      zero_reg         <= zero_next;
      ctrl_reg         <= ctrl_next;
      alu_ctl_reg      <= alu_ctl_next;
      branch_taken_reg <= branch_taken_next;
    end
  end

  assign out_valid    = out_valid_reg;
  assign alu_result   = alu_result_reg;
  assign zero         = zero_reg;
  assign alu_src      = ctrl_reg.alu_src;
  assign mem_to_reg   = ctrl_reg.mem_to_reg;
  assign mem_read     = ctrl_reg.mem_read;
  assign mem_write    = ctrl_reg.mem_write;
  assign branch       = ctrl_reg.branch;
  assign reg_write    = ctrl_reg.reg_write;
  assign alu_op       = ctrl_reg.alu_op;
  assign alu_ctl      = alu_ctl_reg;
  assign branch_taken = branch_taken_reg;

endmodule

// File: tb/tb_rv_ex_decode_alu.sv
// ---------------------------------------------------------------------------
// tb_rv_ex_decode_alu
// Directed vector table, hand-written reset / in_valid sequences and a
// randomized run against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_rv_ex_decode_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        bubble;
  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic        alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write;
  logic [1:0]  alu_op;
  logic [3:0]  alu_ctl;
  logic        branch_taken;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rv_ex_decode_alu #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .bubble       (bubble),
    .instr        (instr),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .imm          (imm),
    .out_valid    (out_valid),
    .alu_result   (alu_result),
    .zero         (zero),
    .alu_src      (alu_src),
    .mem_to_reg   (mem_to_reg),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .branch       (branch),
    .reg_write    (reg_write),
    .alu_op       (alu_op),
    .alu_ctl      (alu_ctl),
    .branch_taken (branch_taken)
  );

  // Observed output bundle; c6 = {alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write}
  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic        zero;
    logic [5:0]  c6;
    logic [1:0]  aop;
    logic [3:0]  ctl;
    logic        bt;
  } obs_t;

  typedef struct packed {
    logic        bub;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    obs_t        exp;
  } vec_t;

  localparam int NVEC = 18;
  vec_t  vecs [NVEC];
  string names [NVEC];

  function automatic obs_t mk(logic [31:0] r, logic z, logic [5:0] c6,
                              logic [1:0] aop, logic [3:0] ctl, logic bt);
    obs_t o;
    o.valid = 1'b1; o.result = r; o.zero = z; o.c6 = c6;
    o.aop = aop; o.ctl = ctl; o.bt = bt;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.valid = out_valid; o.result = alu_result; o.zero = zero;
    o.c6 = {alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write};
    o.aop = alu_op; o.ctl = alu_ctl; o.bt = branch_taken;
    return o;
  endfunction

  // Reference model: what an RV32 execute stage must present for this
  // instruction, derived from the instruction's meaning.
  function automatic obs_t model(logic v, logic bub, logic [31:0] ins,
                                 logic [31:0] a, logic [31:0] rb, logic [31:0] im);
    obs_t o;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        alt;
    logic        is_r, is_i;
    f3  = ins[14:12];
    alt = ins[30];
    o = '0;
    o.valid = v;
    is_r = 1'b0; is_i = 1'b0;
    if (!bub) begin
      case (ins[6:0])
        7'b0110011: begin o.c6 = 6'b000001; o.aop = 2'd2; is_r = 1'b1; end
        7'b0010011: begin o.c6 = 6'b100001; o.aop = 2'd3; is_i = 1'b1; end
        7'b0000011: begin o.c6 = 6'b111001; o.aop = 2'd0; end
        7'b0100011: begin o.c6 = 6'b100100; o.aop = 2'd0; end
        7'b1100011: begin o.c6 = 6'b000010; o.aop = 2'd1; end
        default:    begin o.c6 = 6'b000000; o.aop = 2'd0; end
      endcase
    end
    b = o.c6[5] ? im : rb;
    if (is_r || is_i) begin
      case (f3)
        3'd0: if (is_r && alt) begin o.result = a - b; o.ctl = 4'd6; end
              else             begin o.result = a + b; o.ctl = 4'd2; end
        3'd1: begin o.result = a << (b % 32); o.ctl = 4'd4; end
        3'd2: begin o.result = (int'(a) < int'(b)) ? 32'd1 : 32'd0; o.ctl = 4'd7; end
        3'd3: begin o.result = (a < b) ? 32'd1 : 32'd0; o.ctl = 4'd8; end
        3'd4: begin o.result = a ^ b; o.ctl = 4'd3; end
        3'd5: if (alt) begin o.result = 32'(int'(a) >>> (b % 32)); o.ctl = 4'd13; end
              else     begin o.result = a >> (b % 32); o.ctl = 4'd5; end
        3'd6: begin o.result = a | b; o.ctl = 4'd1; end
        default: begin o.result = a & b; o.ctl = 4'd0; end
      endcase
    end else if (o.c6[1]) begin
      o.result = a - b; o.ctl = 4'd6;
    end else begin
      o.result = a + b; o.ctl = 4'd2;
    end
    o.zero = (o.result == 32'd0);
    o.bt   = o.c6[1] && o.zero;
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = observe();
    checks++;
    if (got === exp) begin
      passed++;
      $display("[%0t] %s ok: %h", $time, name, got);
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic bub, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    in_valid = v; bubble = bub; instr = ins; rs1_val = a; rs2_val = b; imm = im;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    obs_t e;
    // name, bubble, instr, rs1, rs2, imm, expected
    names[0]  = "add";      vecs[0]  = '{1'b0, 32'h002081B3, 32'd7, 32'd5, 32'h0000DEAD, mk(32'd12, 0, 6'b000001, 2'b10, 4'b0010, 0)};
    names[1]  = "sub";      vecs[1]  = '{1'b0, 32'h402081B3, 32'd7, 32'd5, 32'h0000DEAD, mk(32'd2, 0, 6'b000001, 2'b10, 4'b0110, 0)};
    names[2]  = "addi_b30"; vecs[2]  = '{1'b0, 32'h40000093, 32'd10, 32'h99, 32'hFFFFFFFD, mk(32'd7, 0, 6'b100001, 2'b11, 4'b0010, 0)};
    names[3]  = "lw";       vecs[3]  = '{1'b0, 32'h00812083, 32'h100, 32'h77, 32'd8, mk(32'h108, 0, 6'b111001, 2'b00, 4'b0010, 0)};
    names[4]  = "sw";       vecs[4]  = '{1'b0, 32'h0020A423, 32'h200, 32'h33, 32'd4, mk(32'h204, 0, 6'b100100, 2'b00, 4'b0010, 0)};
    names[5]  = "beq_tkn";  vecs[5]  = '{1'b0, 32'h00208463, 32'h55, 32'h55, 32'd8, mk(32'd0, 1, 6'b000010, 2'b01, 4'b0110, 1)};
    names[6]  = "beq_nt";   vecs[6]  = '{1'b0, 32'h00208463, 32'h55, 32'h56, 32'd8, mk(32'hFFFFFFFF, 0, 6'b000010, 2'b01, 4'b0110, 0)};
    names[7]  = "and";      vecs[7]  = '{1'b0, 32'h0020F1B3, 32'hF0F0, 32'h0FF0, 32'd0, mk(32'h00F0, 0, 6'b000001, 2'b10, 4'b0000, 0)};
    names[8]  = "sra";      vecs[8]  = '{1'b0, 32'h4020D1B3, 32'h80000000, 32'd4, 32'd0, mk(32'hF8000000, 0, 6'b000001, 2'b10, 4'b1101, 0)};
    names[9]  = "srl";      vecs[9]  = '{1'b0, 32'h0020D1B3, 32'h80000000, 32'd4, 32'd0, mk(32'h08000000, 0, 6'b000001, 2'b10, 4'b0101, 0)};
    names[10] = "slt";      vecs[10] = '{1'b0, 32'h0020A1B3, 32'hFFFFFFFF, 32'd1, 32'd0, mk(32'd1, 0, 6'b000001, 2'b10, 4'b0111, 0)};
    names[11] = "sltu";     vecs[11] = '{1'b0, 32'h0020B1B3, 32'hFFFFFFFF, 32'd1, 32'd0, mk(32'd0, 1, 6'b000001, 2'b10, 4'b1000, 0)};
    names[12] = "sll_33";   vecs[12] = '{1'b0, 32'h002091B3, 32'd1, 32'd33, 32'd0, mk(32'd2, 0, 6'b000001, 2'b10, 4'b0100, 0)};
    names[13] = "srai";     vecs[13] = '{1'b0, 32'h4040D093, 32'hF0000000, 32'd0, 32'h404, mk(32'hFF000000, 0, 6'b100001, 2'b11, 4'b1101, 0)};
    names[14] = "xor";      vecs[14] = '{1'b0, 32'h0020C1B3, 32'hFF00FF00, 32'h0F0F0F0F, 32'd0, mk(32'hF00FF00F, 0, 6'b000001, 2'b10, 4'b0011, 0)};
    names[15] = "or";       vecs[15] = '{1'b0, 32'h0020E1B3, 32'hF0000000, 32'h0000000F, 32'd0, mk(32'hF000000F, 0, 6'b000001, 2'b10, 4'b0001, 0)};
    names[16] = "bubble_lw"; vecs[16] = '{1'b1, 32'h00812083, 32'h100, 32'h30, 32'd8, mk(32'h130, 0, 6'b000000, 2'b00, 4'b0010, 0)};
    names[17] = "illegal";  vecs[17] = '{1'b0, 32'h0000007F, 32'd3, 32'd4, 32'd100, mk(32'd7, 0, 6'b000000, 2'b00, 4'b0010, 0)};

    // Reset with random inputs: outputs must stay 0.
    rst_n = 1'b0;
    drive(1'b1, 1'($urandom), $urandom, $urandom, $urandom, $urandom);
    step();
    check("reset_c1", obs_t'('0));
    drive(1'b1, 1'($urandom), 32'h002081B3, 32'd7, 32'd5, $urandom);
    step();
    check("reset_c2", obs_t'('0));

    // Release with add: result visible one edge later.
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h002081B3, 32'd7, 32'd5, 32'd0);
    step();
    check("reset_release_add", mk(32'd12, 0, 6'b000001, 2'b10, 4'b0010, 0));

    // Directed table, applied back to back.
    for (int i = 0; i < NVEC; i++) begin
      drive(1'b1, vecs[i].bub, vecs[i].ins, vecs[i].a, vecs[i].b, vecs[i].im);
      step();
      check(names[i], vecs[i].exp);
    end

    // in_valid=0: datapath still registered, out_valid low.
    drive(1'b0, 1'b0, 32'h002081B3, 32'd7, 32'd5, 32'd0);
    step();
    e = mk(32'd12, 0, 6'b000001, 2'b10, 4'b0010, 0);
    e.valid = 1'b0;
    check("invalid_add", e);

    // Reset asserted mid-stream wins over a taken branch.
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h00208463, 32'h55, 32'h55, 32'd8);
    step();
    check("reset_priority", obs_t'('0));
    rst_n = 1'b1;

    // Randomized run against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [6:0]  opcs [6];
      logic [31:0] ins, a, b, im;
      logic        v, bub;
      opcs[0] = 7'b0110011; opcs[1] = 7'b0010011; opcs[2] = 7'b0000011;
      opcs[3] = 7'b0100011; opcs[4] = 7'b1100011; opcs[5] = 7'($urandom);
      ins = $urandom;
      ins[6:0] = opcs[$urandom_range(0, 5)];
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
      im = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      v   = ($urandom_range(0, 7) != 0);
      bub = ($urandom_range(0, 7) == 0);
      drive(v, bub, ins, a, b, im);
      step();
      check($sformatf("rand%0d_%h", i, ins), model(v, bub, ins, a, b, im));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
